// File: rtl/router_pkg.sv
// Shared constants, encodings and FSM state type for the router output arbiter.
package router_pkg;

  localparam int unsigned NumPorts  = 3;

  localparam int unsigned PortX     = 0;
  localparam int unsigned PortY     = 1;
  localparam int unsigned PortLocal = 2;

  localparam int unsigned FailX     = 0;
  localparam int unsigned FailY     = 1;
  localparam int unsigned FailLocal = 2;

  localparam logic [1:0] SelNone  = 2'b00;
  localparam logic [1:0] SelX     = 2'b01;
  localparam logic [1:0] SelY     = 2'b10;
  localparam logic [1:0] SelLocal = 2'b11;

  typedef enum logic {StIdle, StLock} port_state_e;

  // Port index -> mux select / dest encoding.
  function automatic logic [1:0] port_sel(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  function automatic logic [1:0] port_next(input logic [1:0] idx);
    return (idx == 2'(PortLocal)) ? 2'(PortX) : idx + 2'd1;
  endfunction

  // (ptr + off) mod NumPorts, for the round-robin scan.
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= 3'(NumPorts)) sum = sum - 3'(NumPorts);
    return sum[1:0];
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Source-side request/grant and output-side flow-control bundle of the router output arbiter.
interface router_out_arbiter_if #(
  parameter int unsigned PKT_LEN_W = 4
) ();
  logic                 req_x, req_y, req_local;
  logic [1:0]           dest_x, dest_y, dest_local;
  logic [PKT_LEN_W-1:0] len_x, len_y, len_local;
  logic                 flit_vld_x, flit_vld_y, flit_vld_local;
  logic [2:0]           out_rdy;
  logic [2:0]           fail;

  logic                 gnt_x, gnt_y, gnt_local;
  logic                 abort_x, abort_y, abort_local;
  logic                 fwd_rdy_x, fwd_rdy_y, fwd_rdy_local;
  logic [2:0]           out_vld;
  logic [1:0]           control_x, control_y, control_local;
  logic [2:0]           busy;

  modport master (
    output req_x, req_y, req_local, dest_x, dest_y, dest_local,
    output len_x, len_y, len_local, flit_vld_x, flit_vld_y, flit_vld_local,
    output out_rdy, fail,
    input  gnt_x, gnt_y, gnt_local, abort_x, abort_y, abort_local,
    input  fwd_rdy_x, fwd_rdy_y, fwd_rdy_local, out_vld,
    input  control_x, control_y, control_local, busy
  );

  modport slave (
    input  req_x, req_y, req_local, dest_x, dest_y, dest_local,
    input  len_x, len_y, len_local, flit_vld_x, flit_vld_y, flit_vld_local,
    input  out_rdy, fail,
    output gnt_x, gnt_y, gnt_local, abort_x, abort_y, abort_local,
    output fwd_rdy_x, fwd_rdy_y, fwd_rdy_local, out_vld,
    output control_x, control_y, control_local, busy
  );
endinterface

// File: rtl/out_port_fsm.sv
// One output port: round-robin pick among candidates, packet lock, flit counter and pointer.
module out_port_fsm
  import router_pkg::*;
#(
  parameter int unsigned PKT_LEN_W = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumPorts-1:0]                i_cand,
  input  logic [NumPorts-1:0][PKT_LEN_W-1:0] i_len,
  input  logic [NumPorts-1:0]                i_flit_vld,
  input  logic                               i_out_rdy,
  input  logic                               i_fail,
  output logic [NumPorts-1:0]                o_gnt,
  output logic [NumPorts-1:0]                o_abort,
  output logic [NumPorts-1:0]                o_locked,
  output logic                               o_busy,
  output logic                               o_out_vld,
  output logic [1:0]                         o_control
);

  port_state_e          r_state, w_state_d;
  logic [1:0]           r_src, w_src_d;
  logic [PKT_LEN_W-1:0] r_cnt, w_cnt_d;
  logic [1:0]           r_ptr, w_ptr_d;
  logic [NumPorts-1:0]  r_gnt, w_gnt_d;
  logic [NumPorts-1:0]  r_abort, w_abort_d;

  logic                 w_found;
  logic [1:0]           w_pick;
  logic [PKT_LEN_W-1:0] w_len_eff;
  logic                 w_xfer;

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int k = 0; k < NumPorts; k++) begin
      if (!w_found && i_cand[rr_idx(r_ptr, 2'(k))]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_ptr, 2'(k));
      end
    end
  end

  // A zero-length header still moves one flit.
  assign w_len_eff = (i_len[w_pick] == '0) ? {{(PKT_LEN_W-1){1'b0}}, 1'b1} : i_len[w_pick];
  assign w_xfer    = (r_state == StLock) && i_flit_vld[r_src] && i_out_rdy;

  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_cnt_d   = r_cnt;
    w_ptr_d   = r_ptr;
    w_gnt_d   = '0;
    w_abort_d = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d        = StLock;
          w_src_d          = w_pick;
          w_cnt_d          = w_len_eff;
          w_gnt_d[w_pick]  = 1'b1;
        end
      end
      StLock: begin
        // A failing port wins over a coinciding last flit.
        if (i_fail) begin
          w_state_d       = StIdle;
          w_abort_d[r_src] = 1'b1;
        end else if (w_xfer) begin
          w_cnt_d = r_cnt - 1'b1;
          if (r_cnt == {{(PKT_LEN_W-1){1'b0}}, 1'b1}) begin
            w_state_d = StIdle;
            w_ptr_d   = port_next(r_src);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_cnt   <= '0;
      r_ptr   <= 2'(PortX);
      r_gnt   <= '0;
      r_abort <= '0;
    end else begin
      r_state <= w_state_d;
      r_src   <= w_src_d;
      r_cnt   <= w_cnt_d;
      r_ptr   <= w_ptr_d;
      r_gnt   <= w_gnt_d;
      r_abort <= w_abort_d;
    end
  end

  always_comb begin
    o_locked = '0;
    if (r_state == StLock) o_locked[r_src] = 1'b1;
  end

  assign o_gnt     = r_gnt;
  assign o_abort   = r_abort;
  assign o_busy    = (r_state == StLock);
  assign o_out_vld = (r_state == StLock) && i_flit_vld[r_src];
  assign o_control = (r_state == StLock) ? port_sel(r_src) : SelNone;

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter for the 3-port router: candidate masking, per-output FSMs, per-input merge.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int unsigned PKT_LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  router_out_arbiter_if.slave  bus
);

  localparam logic [1:0]  OutSel  [NumPorts] = '{SelX, SelY, SelLocal};
  localparam int unsigned FailBit [NumPorts] = '{FailX, FailY, FailLocal};

  logic [NumPorts-1:0]                w_req;
  logic [NumPorts-1:0][1:0]           w_dest;
  logic [NumPorts-1:0][PKT_LEN_W-1:0] w_len;
  logic [NumPorts-1:0]                w_flit_vld;

  // Indexed [output][source].
  logic [NumPorts-1:0][NumPorts-1:0]  w_cand;
  logic [NumPorts-1:0][NumPorts-1:0]  w_gnt;
  logic [NumPorts-1:0][NumPorts-1:0]  w_abort;
  logic [NumPorts-1:0][NumPorts-1:0]  w_locked;
  logic [NumPorts-1:0][1:0]           w_control;
  logic [NumPorts-1:0]                w_busy;
  logic [NumPorts-1:0]                w_out_vld;

  logic [NumPorts-1:0]                w_src_locked;
  logic [NumPorts-1:0]                w_gnt_in;
  logic [NumPorts-1:0]                w_abort_in;
  logic [NumPorts-1:0]                w_fwd_rdy;

  assign w_req      = {bus.req_local, bus.req_y, bus.req_x};
  assign w_dest     = {bus.dest_local, bus.dest_y, bus.dest_x};
  assign w_len      = {bus.len_local, bus.len_y, bus.len_x};
  assign w_flit_vld = {bus.flit_vld_local, bus.flit_vld_y, bus.flit_vld_x};

  always_comb begin
    w_src_locked = '0;
    w_gnt_in     = '0;
    w_abort_in   = '0;
    w_fwd_rdy    = '0;
    for (int o = 0; o < NumPorts; o++) begin
      w_src_locked = w_src_locked | w_locked[o];
      w_gnt_in     = w_gnt_in | w_gnt[o];
      w_abort_in   = w_abort_in | w_abort[o];
      w_fwd_rdy    = w_fwd_rdy | (w_locked[o] & {NumPorts{bus.out_rdy[o]}});
    end
  end

  // A source already holding a connection cannot be picked again.
  always_comb begin
    w_cand = '0;
    for (int o = 0; o < NumPorts; o++) begin
      for (int s = 0; s < NumPorts; s++) begin
        w_cand[o][s] = w_req[s] && (w_dest[s] == OutSel[o]) && !w_src_locked[s] &&
                       !bus.fail[FailBit[o]];
      end
    end
  end

  for (genvar o = 0; o < NumPorts; o++) begin : g_port
    out_port_fsm #(
      .PKT_LEN_W (PKT_LEN_W)
    ) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cand     (w_cand[o]),
      .i_len      (w_len),
      .i_flit_vld (w_flit_vld),
      .i_out_rdy  (bus.out_rdy[o]),
      .i_fail     (bus.fail[FailBit[o]]),
      .o_gnt      (w_gnt[o]),
      .o_abort    (w_abort[o]),
      .o_locked   (w_locked[o]),
      .o_busy     (w_busy[o]),
      .o_out_vld  (w_out_vld[o]),
      .o_control  (w_control[o])
    );
  end

  assign bus.gnt_x         = w_gnt_in[PortX];
  assign bus.gnt_y         = w_gnt_in[PortY];
  assign bus.gnt_local     = w_gnt_in[PortLocal];
  assign bus.abort_x       = w_abort_in[PortX];
  assign bus.abort_y       = w_abort_in[PortY];
  assign bus.abort_local   = w_abort_in[PortLocal];
  assign bus.fwd_rdy_x     = w_fwd_rdy[PortX];
  assign bus.fwd_rdy_y     = w_fwd_rdy[PortY];
  assign bus.fwd_rdy_local = w_fwd_rdy[PortLocal];
  assign bus.out_vld       = w_out_vld;
  assign bus.busy          = w_busy;
  assign bus.control_x     = w_control[PortX];
  assign bus.control_y     = w_control[PortY];
  assign bus.control_local = w_control[PortLocal];

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: hand-computed grant/select/flow-control sequences.
module tb_router_out_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  router_out_arbiter_if #(.PKT_LEN_W(4)) bus ();

  router_out_arbiter #(
    .PKT_LEN_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, sample just after the edge; sources drop req once granted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.gnt_x)     bus.req_x     = 1'b0;
    if (bus.gnt_y)     bus.req_y     = 1'b0;
    if (bus.gnt_local) bus.req_local = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.req_x = 1'b0; bus.req_y = 1'b0; bus.req_local = 1'b0;
    bus.dest_x = 2'b00; bus.dest_y = 2'b00; bus.dest_local = 2'b00;
    bus.len_x = 4'd0; bus.len_y = 4'd0; bus.len_local = 4'd0;
    bus.flit_vld_x = 1'b0; bus.flit_vld_y = 1'b0; bus.flit_vld_local = 1'b0;
    bus.out_rdy = 3'b111;
    bus.fail = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.control_x, bus.control_y, bus.control_local} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_control: got %b want 000000",
               {bus.control_x, bus.control_y, bus.control_local});
    end
    n_checks++;
    if ({bus.busy, bus.out_vld} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_busy_vld: got %b want 000000", {bus.busy, bus.out_vld});
    end
    n_checks++;
    if ({bus.gnt_x, bus.gnt_y, bus.gnt_local, bus.abort_x, bus.abort_y, bus.abort_local}
        !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_pulses: got %b want 000000",
               {bus.gnt_x, bus.gnt_y, bus.gnt_local, bus.abort_x, bus.abort_y,
                bus.abort_local});
    end
    rst_n = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] exp_ctl [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic       exp_gnt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.req_y = 1'b1; bus.dest_y = 2'b01; bus.len_y = 4'd3; bus.flit_vld_y = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.control_x !== exp_ctl[i] || bus.gnt_y !== exp_gnt[i]) begin
        n_errors++;
        $display("FAIL single_cycle%0d: got ctl_x=%b gnt_y=%b want ctl_x=%b gnt_y=%b",
                 i + 1, bus.control_x, bus.gnt_y, exp_ctl[i], exp_gnt[i]);
      end
      if (i == 0) begin
        n_checks++;
        if ({bus.busy, bus.out_vld, bus.fwd_rdy_y} !== 7'b001_001_1) begin
          n_errors++;
          $display("FAIL single_flow: got busy/vld/fwd=%b want 0010011",
                   {bus.busy, bus.out_vld, bus.fwd_rdy_y});
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_ctl [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                                2'b11, 2'b11, 2'b00};
    // {local, y, x}
    logic [2:0] exp_gnt [9] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
                                3'b100, 3'b000, 3'b000};
    bus.req_x = 1'b1; bus.req_y = 1'b1; bus.req_local = 1'b1;
    bus.dest_x = 2'b11; bus.dest_y = 2'b11; bus.dest_local = 2'b11;
    bus.len_x = 4'd2; bus.len_y = 4'd2; bus.len_local = 4'd2;
    bus.flit_vld_x = 1'b1; bus.flit_vld_y = 1'b1; bus.flit_vld_local = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (bus.control_local !== exp_ctl[i] ||
          {bus.gnt_local, bus.gnt_y, bus.gnt_x} !== exp_gnt[i]) begin
        n_errors++;
        $display("FAIL contention_cycle%0d: got ctl=%b gnt=%b want ctl=%b gnt=%b",
                 i + 1, bus.control_local, {bus.gnt_local, bus.gnt_y, bus.gnt_x},
                 exp_ctl[i], exp_gnt[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_fairness();
    // {y, x}
    logic [1:0] exp_gnt [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    bus.dest_x = 2'b10; bus.dest_y = 2'b10; bus.len_x = 4'd1; bus.len_y = 4'd1;
    bus.flit_vld_x = 1'b1; bus.flit_vld_y = 1'b1;
    bus.req_x = 1'b1; bus.req_y = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({bus.gnt_y, bus.gnt_x} !== exp_gnt[i]) begin
        n_errors++;
        $display("FAIL fairness_cycle%0d: got gnt_yx=%b want %b",
                 i + 1, {bus.gnt_y, bus.gnt_x}, exp_gnt[i]);
      end
      if (!bus.gnt_x) bus.req_x = 1'b1;
      if (!bus.gnt_y) bus.req_y = 1'b1;
    end
    bus.req_x = 1'b0; bus.req_y = 1'b0;
    tick();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [2:0] rdy_tab [8] = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [1:0] exp_ctl [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic       exp_fwd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.req_y = 1'b1; bus.dest_y = 2'b11; bus.len_y = 4'd4; bus.flit_vld_y = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.out_rdy = rdy_tab[i];
      #1;
      n_checks++;
      if (bus.control_local !== exp_ctl[i] || bus.fwd_rdy_y !== exp_fwd[i]) begin
        n_errors++;
        $display("FAIL backpressure_cycle%0d: got ctl=%b fwd_y=%b want ctl=%b fwd_y=%b",
                 i + 1, bus.control_local, bus.fwd_rdy_y, exp_ctl[i], exp_fwd[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_fail();
    bus.req_local = 1'b1; bus.dest_local = 2'b01; bus.len_local = 4'd5;
    bus.flit_vld_local = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt_local !== 1'b1 || bus.control_x !== 2'b11) begin
      n_errors++;
      $display("FAIL fail_grant: got gnt=%b ctl_x=%b want 1 11", bus.gnt_local, bus.control_x);
    end
    tick();
    bus.fail = 3'b001;
    tick();
    n_checks++;
    if (bus.abort_local !== 1'b1 || bus.control_x !== 2'b00 || bus.busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL fail_abort: got abort=%b ctl_x=%b busy0=%b want 1 00 0",
               bus.abort_local, bus.control_x, bus.busy[0]);
    end
    bus.req_y = 1'b1; bus.dest_y = 2'b01; bus.len_y = 4'd0; bus.flit_vld_y = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt_y !== 1'b0 || bus.abort_local !== 1'b0 || bus.control_x !== 2'b00) begin
      n_errors++;
      $display("FAIL fail_block: got gnt_y=%b abort=%b ctl_x=%b want 0 0 00",
               bus.gnt_y, bus.abort_local, bus.control_x);
    end
    bus.fail = 3'b000;
    tick();
    n_checks++;
    if (bus.gnt_y !== 1'b1 || bus.control_x !== 2'b10) begin
      n_errors++;
      $display("FAIL fail_recover: got gnt_y=%b ctl_x=%b want 1 10", bus.gnt_y, bus.control_x);
    end
    tick();
    n_checks++;
    if (bus.control_x !== 2'b00 || bus.busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL len_zero: got ctl_x=%b busy0=%b want 00 0", bus.control_x, bus.busy[0]);
    end
    clear_inputs();
  endtask

  task automatic test_parallel_reset();
    bus.req_x = 1'b1; bus.dest_x = 2'b10;
    bus.req_y = 1'b1; bus.dest_y = 2'b11;
    bus.req_local = 1'b1; bus.dest_local = 2'b01;
    bus.len_x = 4'd8; bus.len_y = 4'd8; bus.len_local = 4'd8;
    bus.flit_vld_x = 1'b1; bus.flit_vld_y = 1'b1; bus.flit_vld_local = 1'b1;
    tick();
    n_checks++;
    if ({bus.gnt_x, bus.gnt_y, bus.gnt_local} !== 3'b111 ||
        {bus.control_x, bus.control_y, bus.control_local} !== 6'b11_01_10 ||
        bus.busy !== 3'b111) begin
      n_errors++;
      $display("FAIL parallel_grant: got gnt=%b ctl=%b busy=%b want 111 110110 111",
               {bus.gnt_x, bus.gnt_y, bus.gnt_local},
               {bus.control_x, bus.control_y, bus.control_local}, bus.busy);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({bus.control_x, bus.control_y, bus.control_local} !== 6'b0 || bus.busy !== 3'b000 ||
        {bus.abort_x, bus.abort_y, bus.abort_local} !== 3'b000) begin
      n_errors++;
      $display("FAIL midpacket_reset: got ctl=%b busy=%b abort=%b want 000000 000 000",
               {bus.control_x, bus.control_y, bus.control_local}, bus.busy,
               {bus.abort_x, bus.abort_y, bus.abort_local});
    end
    rst_n = 1'b0;
    clear_inputs();
    // Pointer must be back at x: x beats local for output x.
    bus.req_x = 1'b1; bus.dest_x = 2'b01; bus.len_x = 4'd1; bus.flit_vld_x = 1'b1;
    bus.req_local = 1'b1; bus.dest_local = 2'b01; bus.len_local = 4'd1;
    bus.flit_vld_local = 1'b1;
    tick();
    n_checks++;
    if ({bus.gnt_x, bus.gnt_local} !== 2'b10 || bus.control_x !== 2'b01) begin
      n_errors++;
      $display("FAIL reset_ptr: got gnt_x/local=%b ctl_x=%b want 10 01",
               {bus.gnt_x, bus.gnt_local}, bus.control_x);
    end
    tick();
    tick();
    n_checks++;
    if (bus.gnt_local !== 1'b1 || bus.control_x !== 2'b11) begin
      n_errors++;
      $display("FAIL back_to_back: got gnt_local=%b ctl_x=%b want 1 11",
               bus.gnt_local, bus.control_x);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_fail();
    test_parallel_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Output-port arbiter and connection sequencer for the 3-port (x, y, local) router. It takes per-input destination requests from the routing algorithm and resolves contention for each output with an independent round-robin arbiter. It locks a granted input→output connection for a whole packet and drives the data_selector41 mux selects `control_x/y/local`. Unlike the single-cycle destination→select translation, conflicting requests are serialised, never overwritten.

## Interface
- `PKT_LEN_W`, default 4: width of the packet-length field, in flits.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-high (1 = reset).
- `req_x`, `req_y`, `req_local`  in  1 each: input port has a packet header waiting.
- `dest_x`, `dest_y`, `dest_local`  in  2 each: routing result. 00 = none, 01 = x, 10 = y, 11 = local.
- `len_x`, `len_y`, `len_local`  in  PKT_LEN_W each: flits in the packet, header included. Sampled on grant.
- `flit_vld_x`, `flit_vld_y`, `flit_vld_local`  in  1 each: source has a flit this cycle.
- `out_rdy`  in  3: downstream ready. Bit 0 = x, 1 = y, 2 = local.
- `fail`  in  3: output port disabled. Same bit order as `out_rdy`.
- `gnt_x`, `gnt_y`, `gnt_local`  out  1 each: 1-cycle grant pulse to the source.
- `abort_x`, `abort_y`, `abort_local`  out  1 each: 1-cycle pulse when the source's connection is killed by `fail`.
- `fwd_rdy_x`, `fwd_rdy_y`, `fwd_rdy_local`  out  1 each: source may advance a flit (combinational).
- `out_vld`  out  3: output port carries a valid flit (combinational).
- `control_x`, `control_y`, `control_local`  out  2 each: mux select. 00 = none, 01 = from x, 10 = from y, 11 = from local.
- `busy`  out  3: output port locked.

## Operation
- Each output port o has its own FSM with states IDLE and LOCK. It holds registers `src_o` (2b), `cnt_o` (PKT_LEN_W), `ptr_o` (round-robin pointer).
- An input s is a candidate for o when:
  - `req_s`=1,
  - `dest_s` selects o,
  - s is not currently locked to any output, and
  - `fail[o]`=0.
  U-turns (x→x, local→local) are legal.
- **IDLE**: if any candidate exists, pick the first one at or after `ptr_o` in the order x, y, local (wrapping). Then:
  - register `src_o`,
  - set `cnt_o` = `len_s`, with `len_s`=0 treated as 1,
  - pulse `gnt_s`,
  - go to LOCK.
- **LOCK**:
  - Transfer condition: `flit_vld_src` & `out_rdy[o]`.
  - On a transfer, decrement `cnt_o`. When a transfer occurs with `cnt_o`=1, go to IDLE and set `ptr_o` = winner+1 (mod 3).
  - If `fail[o]` rises during LOCK, go to IDLE, pulse `abort_src`, and leave `ptr_o` unchanged. `fail` overrides a simultaneous last transfer.
- `control_o` = 00 in IDLE. In LOCK it is the encoding of `src_o`.
- `fwd_rdy_s` = `out_rdy[o]` of the output locked to s, else 0.
- `out_vld[o]` = LOCK & `flit_vld_src`.
- The source must drop `req_s` in the cycle after `gnt_s`. A `req_s` that stays high while s is locked is ignored.
- The three outputs arbitrate in parallel. Each input targets one output, so no input is ever granted twice.

## Timing
- Reset values:
  - all FSMs IDLE,
  - `control_*` = 00,
  - `gnt_*`, `abort_*`, `busy` = 0,
  - `cnt` = 0,
  - `ptr` = x.
- Reset mid-packet drops the connection immediately, with no abort pulse.
- Request sampled at edge t: `gnt` pulse, `busy`, and `control_o` are valid in cycle t+1.
- The first flit can transfer in cycle t+1.
- Last transfer in cycle k: `control_o` = 00 and `busy` = 0 in k+1. The next grant becomes visible in k+2, giving one mandatory bubble.
- `fail[o]` high in cycle k during LOCK: `abort` pulses and `control_o` = 00 in k+1.
- `out_rdy` = 0 stalls the counter indefinitely; there is no timeout.

## Structure
- Shared package `router_pkg` holds:
  - port index constants (X=0, Y=1, LOCAL=2),
  - dest/select encodings (NONE=00, X=01, Y=10, LOCAL=11),
  - fail bit positions,
  - the FSM state enum.
- Sub-module `out_port_fsm` contains one output's round-robin pick, FSM, counter and pointer. It is instantiated three times. The top level does the candidate masking, "source already locked" gating, and the OR-combination of `gnt`, `abort` and `fwd_rdy` into per-input signals.

## Test plan
- Single packet: reset; `req_y`=1, `dest_y`=01, `len_y`=3; `flit_vld_y`=1 and `out_rdy`=111 held → `gnt_y` at t+1, `control_x`=10 for exactly 3 cycles, then 00.
- Contention: x, y and local all request local (dest=11), len=2 each, in the same cycle → grants in order x, y, local. `control_local` sequence: 01,01,00,10,10,00,11,11,00.
- Round-robin fairness: x and y repeatedly request y, len=1 → grants alternate x, y, x, y, with no starvation.
- Backpressure: locked y→local, len=4, `out_rdy[2]` low for 3 cycles mid-packet → `cnt` holds, `fwd_rdy_y`=0, and the connection spans 4+3 cycles.
- Fail: during LOCK of local→x, assert `fail`=001 → `abort_local` pulse and `control_x`=00 next cycle; a new request to x is not granted while `fail[0]`=1.
- Parallel and reset: x→y, y→local and local→x all granted in the same cycle; assert `rst_n`=1 mid-packet → all `control_*`=00 next cycle.
